// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  function automatic int unsigned calc_bit_cycles(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Start bit + data bits + one stop bit.
  function automatic int unsigned calc_frame_cycles(input int unsigned data_width,
                                                    input int unsigned bit_cycles);
    return (data_width + 2) * bit_cycles;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter; restarts from zero whenever a new frame is popped.
module baud_tick_gen #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    if (clear || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops words straight from an upstream FIFO whenever it is free.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  if (BIT_CYCLES < 2) begin : gen_bad_baud
    $error("uart_tx_fifo_drain: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  bit_end;
  logic                  pop;

  baud_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (pop),
    .bit_end(bit_end)
  );

  // The FIFO is only sampled when idle or in the very last stop cycle.
  assign pop = ((state_q == StIdle) || ((state_q == StStop) && bit_end)) &&
               !fifo_empty && reset;

  assign fifo_rd = pop;
  assign tx_done = (state_q == StStop) && bit_end;
  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          shift_d = fifo_rd_data;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (pop) begin
          state_d = StStart;
          shift_d = fifo_rd_data;
        end else if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so tx changes exactly on bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: a queue-based FIFO feeds the transmitter; a monitor checks every line cycle.
module tb_uart_tx_fifo_drain;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned BAUD_RATE = 100;
  localparam int unsigned DW        = 8;
  localparam int          BITC      = int'(calc_bit_cycles(CLK_FREQ, BAUD_RATE));
  localparam int          FRAME     = int'(calc_frame_cycles(DW, calc_bit_cycles(CLK_FREQ,
                                                                             BAUD_RATE)));

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          fifo_empty   = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd, tx, tx_busy, tx_done;

  int            vectors     = 0;
  int            miscompares = 0;
  int            pops        = 0;
  int            fcnt        = -1;  // index of the current cycle within a frame, -1 when idle
  logic [DW-1:0] cur         = '0;
  logic          rd_seen     = 1'b0;
  logic          glitch      = 1'b0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  uart_tx_fifo_drain #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Line level of an 8N1 frame at cycle k after the pop edge.
  function automatic logic exp_line(input int k, input logic [DW-1:0] w);
    int b;
    b = k / BITC;
    if (k < 0) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= int'(DW)) return w[b-1];
    return 1'b1;
  endfunction

  // FIFO model: pops on an observed strobe, presents its head combinationally.
  always @(posedge clk) begin
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    if (glitch) begin
      fifo_empty   = 1'($urandom_range(0, 1));
      fifo_rd_data = DW'($urandom);
    end else begin
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_tx", tx, 1);
      check("reset_tx_busy", tx_busy, 0);
      check("reset_tx_done", tx_done, 0);
      check("reset_fifo_rd", fifo_rd, 0);
      fcnt    = -1;
      rd_seen = 1'b0;
    end else begin
      check("tx", tx, exp_line(fcnt, cur));
      check("tx_busy", tx_busy, fcnt >= 0);
      check("tx_done", tx_done, fcnt == FRAME - 1);
      check("fifo_rd", fifo_rd, (fcnt < 0 || fcnt == FRAME - 1) && !fifo_empty);
      rd_seen = fifo_rd;
      if (fifo_rd) begin
        pops++;
        check("pop_has_word", exp_q.size() > 0, 1);
        cur  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        fcnt = 0;
      end else if (fcnt == FRAME - 1) begin
        fcnt = -1;
      end else if (fcnt >= 0) begin
        fcnt++;
      end
    end
  end

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (fcnt < 0 && fifo_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    check("drain_within_budget", done, 1);
  endtask

  task automatic wait_fcnt(input int target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      #1;
      if (fcnt == target) hit = 1'b1;
    end
    check("reach_frame_pos", hit, 1);
  endtask

  initial begin
    int p0;
    #1 reset = 1'b0;

    // Word waiting during reset: no pop until release, then pop at once.
    push(8'hA5);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    p0 = pops;
    wait_idle(FRAME + 20);
    check("single_pop_count", pops - p0, 1);

    // Back-to-back frames with no idle gap.
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    wait_idle(2 * FRAME + 20);
    check("b2b_pop_count", pops - p0, 2);

    // Empty FIFO for a long stretch.
    p0 = pops;
    repeat (500) @(posedge clk);
    check("idle_pop_count", pops - p0, 0);

    // FIFO inputs wander mid-frame; byte in flight must be unaffected.
    p0 = pops;
    push(8'h3C);
    wait_fcnt(25, 50);
    glitch = 1'b1;
    wait_fcnt(80, 100);
    glitch = 1'b0;
    wait_idle(FRAME + 20);
    check("glitch_pop_count", pops - p0, 1);

    // Reset during data bit 3 of 0x55 with another word already queued.
    p0 = pops;
    push(8'h55);
    push(8'h99);
    wait_fcnt(45, 100);
    check("pre_reset_tx", tx, 0);
    reset = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_tx_busy", tx_busy, 0);
    check("async_reset_fifo_rd", fifo_rd, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    wait_idle(FRAME + 20);
    check("reset_frame_pop_count", pops - p0, 2);

    // Random words at random spacing.
    p0 = pops;
    for (int i = 0; i < 24; i++) begin
      push(DW'($urandom));
      repeat ($urandom_range(0, 160)) @(posedge clk);
      #2;
    end
    wait_idle(24 * FRAME + 500);
    check("random_pop_count", pops - p0, 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
